ex_stage_pipe: RTL and testbench

Registered, parametrised execute stage for the RISC pipeline. It replaces the purely combinational execute path with an EX/MEM boundary register, adds a multi-cycle shift-add multiplier and signed branch conditions, and uses a valid/stall/flush handshake. It sits between the decode/register-read stage and the data-memory stage. Operand width and register-address width are configurable.

---
 rtl/ex_stage_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU, signed branch conditions, shift-add multiplier,
// and the EX/MEM boundary register with valid/stall/flush handshake.
module ex_stage_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_W   = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            busy,
  input  logic            stall_in,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic            alu_src,
  input  logic            mem_write_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic            branch_in,
  input  logic            jump,
  input  logic            jr,
  input  logic [1:0]      br_cond,
  input  logic [XLEN-1:0] dato1,
  input  logic [XLEN-1:0] dato2,
  input  logic [XLEN-1:0] inm_ext,
  input  logic [XLEN-1:0] pc_in,
  input  logic [RA_W-1:0] dest_in,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] data_wr_mem,
  output logic [XLEN-1:0] pc_target,
  output logic            take_branch,
  output logic [RA_W-1:0] dest_out,
  output logic            reg_write_out,
  output logic            mem_to_reg_out,
  output logic            mem_write_out
);
  localparam int unsigned SH_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [SH_W-1:0] r_cnt;
  logic [XLEN-1:0] r_ma;
  logic [XLEN-1:0] r_mb;
  logic [XLEN-1:0] r_prod;
  logic [XLEN-1:0] r_wd;
  logic [XLEN-1:0] r_pct;
  logic            r_tb;
  logic            r_rw;
  logic            r_m2r;
  logic            r_mw;
  logic [RA_W-1:0] r_dest;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [SH_W-1:0] w_sh;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_pct;
  logic            w_slt;
  logic            w_lt;
  logic            w_cond;
  logic            w_tb;
  logic            w_accept;
  logic            w_is_mul;

  assign w_a      = mem_write_in ? dato2 : dato1;
  assign w_b      = alu_src ? inm_ext : dato2;
  assign w_sh     = w_b[SH_W-1:0];
  assign w_slt    = $signed(w_a) < $signed(w_b);
  assign w_lt     = $signed(dato1) < $signed(dato2);
  assign w_tb     = jump | (branch_in & w_cond);
  assign w_pct    = jump ? (jr ? dato1 + inm_ext : inm_ext) : pc_in + inm_ext;
  assign w_is_mul = MUL_EN && (op == 4'd9);
  assign busy     = stall_in | (r_state != S_IDLE);
  assign w_accept = in_valid & ~busy & ~flush;

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      2'b00:   w_cond = (dato1 == dato2);
      2'b01:   w_cond = (dato1 != dato2);
      2'b10:   w_cond = w_lt;
      default: w_cond = ~w_lt;
    endcase
  end

  // op 9 is zero here: with MUL_EN the result comes from the sequential multiplier
  always_comb begin
    w_alu = '0;
    case (op)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a & w_b;
      4'd3:    w_alu = w_a | w_b;
      4'd4:    w_alu = w_a ^ w_b;
      4'd5:    w_alu = {{(XLEN-1){1'b0}}, w_slt};
      4'd6:    w_alu = w_a << w_sh;
      4'd7:    w_alu = w_a >> w_sh;
      4'd8:    w_alu = XLEN'($signed(w_a) >>> w_sh);
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_prod  <= '0;
      r_wd    <= '0;
      r_pct   <= '0;
      r_tb    <= 1'b0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_mw    <= 1'b0;
      r_dest  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= S_MUL;
            r_cnt   <= SH_W'(XLEN - 1);
            r_ma    <= w_a;
            r_mb    <= w_b;
            r_prod  <= '0;
            r_wd    <= dato1;
            r_pct   <= w_pct;
            r_tb    <= w_tb;
            r_rw    <= reg_write_in;
            r_m2r   <= mem_to_reg_in;
            r_mw    <= mem_write_in;
            r_dest  <= dest_in;
          end
        end
        S_MUL: begin
          if (r_mb[0]) r_prod <= r_prod + r_ma;
          r_ma <= r_ma << 1;
          r_mb <= r_mb >> 1;
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - SH_W'(1);
        end
        S_DONE: begin
          if (!stall_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A stall holds everything; an unstalled cycle with nothing to load is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      alu_out        <= '0;
      data_wr_mem    <= '0;
      pc_target      <= '0;
      take_branch    <= 1'b0;
      dest_out       <= '0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      take_branch    <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (!stall_in) begin
        out_valid      <= 1'b1;
        alu_out        <= r_prod;
        data_wr_mem    <= r_wd;
        pc_target      <= r_pct;
        take_branch    <= r_tb;
        dest_out       <= r_dest;
        reg_write_out  <= r_rw;
        mem_to_reg_out <= r_m2r;
        mem_write_out  <= r_mw;
      end
    end else if (w_accept && !w_is_mul) begin
      out_valid      <= 1'b1;
      alu_out        <= w_alu;
      data_wr_mem    <= dato1;
      pc_target      <= w_pct;
      take_branch    <= w_tb;
      dest_out       <= dest_in;
      reg_write_out  <= reg_write_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_write_out  <= mem_write_in;
    end else if (!stall_in) begin
      out_valid     <= 1'b0;
      take_branch   <= 1'b0;
      reg_write_out <= 1'b0;
      mem_write_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed stimulus pushes expected results,
// a negedge monitor pops and compares each newly loaded EX/MEM value.
module tb_ex_stage_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, busy, stall_in, flush;
  logic [3:0]  op;
  logic        alu_src, mem_write_in, reg_write_in, mem_to_reg_in, branch_in, jump, jr;
  logic [1:0]  br_cond;
  logic [31:0] dato1, dato2, inm_ext, pc_in;
  logic [3:0]  dest_in;
  logic        out_valid;
  logic [31:0] alu_out, data_wr_mem, pc_target;
  logic        take_branch;
  logic [3:0]  dest_out;
  logic        reg_write_out, mem_to_reg_out, mem_write_out;

  ex_stage_pipe #(.XLEN(32), .RA_W(4), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .busy(busy), .stall_in(stall_in),
    .flush(flush), .op(op), .alu_src(alu_src), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
    .jump(jump), .jr(jr), .br_cond(br_cond), .dato1(dato1), .dato2(dato2),
    .inm_ext(inm_ext), .pc_in(pc_in), .dest_in(dest_in), .out_valid(out_valid),
    .alu_out(alu_out), .data_wr_mem(data_wr_mem), .pc_target(pc_target),
    .take_branch(take_branch), .dest_out(dest_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd, pct;
    logic        tb;
    logic [3:0]  dest;
    logic        rw, m2r, mw;
    int          edge_n;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   vec = 0;
  int   err = 0;
  int   cyc = 0;
  int   nbusy;
  logic last_stall;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst)
    if (rst) last_stall <= 1'b0;
    else     last_stall <= stall_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] alu, wd, pct, input logic tb,
                              input logic [3:0] dest, input logic rw, m2r, mw);
    exp_t e;
    e.alu = alu; e.wd = wd; e.pct = pct; e.tb = tb;
    e.dest = dest; e.rw = rw; e.m2r = m2r; e.mw = mw; e.edge_n = 0;
    return e;
  endfunction

  // a held output (stall at the last edge) was already compared when it was loaded
  always @(negedge clk) begin
    if (!rst && out_valid && !last_stall) begin
      if (q.size() == 0) begin
        vec++; err++;
        $display("FAIL unexpected_output: actual alu_out=%h dest=%0d, required no output",
                 alu_out, dest_out);
      end else begin
        m_e = q.pop_front();
        chk("alu_out", alu_out, m_e.alu);
        chk("data_wr_mem", data_wr_mem, m_e.wd);
        chk("pc_target", pc_target, m_e.pct);
        chk("take_branch", take_branch, m_e.tb);
        chk("dest_out", dest_out, m_e.dest);
        chk("ctrl_rw_m2r_mw", {reg_write_out, mem_to_reg_out, mem_write_out},
            {m_e.rw, m_e.m2r, m_e.mw});
        chk("out_edge", cyc, m_e.edge_n);
      end
    end else if (!rst && !out_valid) begin
      chk("bubble_ctrl", {reg_write_out, mem_write_out, take_branch}, 32'd0);
    end
  end

  task automatic clr();
    in_valid = 0; stall_in = 0; flush = 0; op = 0; alu_src = 0; mem_write_in = 0;
    reg_write_in = 0; mem_to_reg_in = 0; branch_in = 0; jump = 0; jr = 0; br_cond = 0;
    dato1 = 0; dato2 = 0; inm_ext = 0; pc_in = 0; dest_in = 0;
  endtask

  task automatic issue(input exp_t e, input int lat);
    in_valid = 1'b1;
    @(posedge clk); #1;
    e.edge_n = cyc + lat;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  // register-write ALU op with pc_in=0, so pc_target equals the immediate
  task automatic alu_row(input logic [3:0] o, input logic [31:0] d1, d2, imm,
                         input logic src, input logic [31:0] res);
    clr();
    op = o; dato1 = d1; dato2 = d2; inm_ext = imm; alu_src = src;
    reg_write_in = 1; dest_in = 4'd9;
    issue(mk(res, d1, imm, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0), 0);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_ctrl", {take_branch, reg_write_out, mem_to_reg_out, mem_write_out}, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADD 5 + 0xFFFFFFFF
    op = 0; dato1 = 5; alu_src = 1; inm_ext = 32'hFFFF_FFFF; reg_write_in = 1; dest_in = 1;
    chk("add_busy", busy, 0);
    issue(mk(32'd4, 32'd5, 32'hFFFF_FFFF, 0, 4'd1, 1, 0, 0), 0);
    chk("add_busy_after", busy, 0);

    // signed branch lt / ge, issued back to back
    clr();
    op = 0; branch_in = 1; br_cond = 2'b10; dato1 = 32'hFFFF_FFFE; dato2 = 1;
    pc_in = 32'h100; inm_ext = 32'h20;
    issue(mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h120, 1, 0, 0, 0, 0), 0);
    br_cond = 2'b11;
    issue(mk(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h120, 0, 0, 0, 0, 0), 0);
    br_cond = 2'b00; dato1 = 7; dato2 = 7; pc_in = 32'h40; inm_ext = 8;
    issue(mk(32'hE, 32'd7, 32'h48, 1, 0, 0, 0, 0), 0);
    br_cond = 2'b01;
    issue(mk(32'hE, 32'd7, 32'h48, 0, 0, 0, 0, 0), 0);

    // ALU table
    alu_row(4'd1, 32'd3, 32'd5, 0, 0, 32'hFFFF_FFFE);
    alu_row(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 32'h00F0_00F0);
    alu_row(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 32'hFFF0_FFF0);
    alu_row(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 32'hFF00_FF00);
    alu_row(4'd5, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1);
    alu_row(4'd5, 32'd1, 32'hFFFF_FFFF, 0, 0, 32'd0);
    alu_row(4'd6, 32'd1, 0, 32'd31, 1, 32'h8000_0000);
    alu_row(4'd6, 32'd3, 0, 32'h21, 1, 32'd6);
    alu_row(4'd7, 32'h8000_0000, 0, 32'd4, 1, 32'h0800_0000);
    alu_row(4'd12, 32'd5, 32'd5, 0, 0, 32'd0);

    // store swaps operand A to dato2; load marks mem_to_reg
    clr();
    mem_write_in = 1; dato1 = 32'h11; dato2 = 32'h100; alu_src = 1; inm_ext = 4;
    issue(mk(32'h104, 32'h11, 32'd4, 0, 0, 0, 0, 1), 0);
    clr();
    mem_to_reg_in = 1; reg_write_in = 1; dest_in = 4'd8; dato1 = 32'h200; alu_src = 1; inm_ext = 32'h10;
    issue(mk(32'h210, 32'h200, 32'h10, 0, 4'd8, 1, 1, 0), 0);

    // MUL 7 x 6 with upstream operands changing after accept
    clr();
    op = 9; dato1 = 7; dato2 = 6; dest_in = 3; reg_write_in = 1;
    issue(mk(32'd42, 32'd7, 32'd0, 0, 4'd3, 1, 0, 0), 33);
    dato1 = 32'h1234; dato2 = 32'h55; op = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", nbusy, 33);

    // MUL wrap-around
    clr();
    op = 9; dato1 = 32'hFFFF_FFFF; dato2 = 2; dest_in = 5; reg_write_in = 1;
    issue(mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 0, 4'd5, 1, 0, 0), 33);
    clr();
    repeat (40) begin @(posedge clk); #1; end

    // stall holds result 9, then the pending ADD enters one edge after release
    clr();
    op = 0; dato1 = 4; alu_src = 1; inm_ext = 5; reg_write_in = 1; dest_in = 2;
    issue(mk(32'd9, 32'd4, 32'd5, 0, 4'd2, 1, 0, 0), 0);
    stall_in = 1; in_valid = 1; dato1 = 10; dato2 = 3; alu_src = 0; inm_ext = 0; dest_in = 6;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_alu_hold", alu_out, 32'd9);
      chk("stall_busy", busy, 1);
    end
    stall_in = 0;
    m_e = mk(32'd13, 32'd10, 32'd0, 0, 4'd6, 1, 0, 0);
    m_e.edge_n = cyc + 1;
    q.push_back(m_e);
    @(posedge clk); #1;
    in_valid = 0;

    // flush mid-MUL, with a competing instruction presented during the flush
    clr();
    op = 9; dato1 = 3; dato2 = 3; dest_in = 7; reg_write_in = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_pre_busy", busy, 1);
    flush = 1; in_valid = 1; op = 0; dato1 = 32'hAA;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    clr();
    op = 0; dato1 = 1; alu_src = 1; inm_ext = 1; reg_write_in = 1; dest_in = 1;
    issue(mk(32'd2, 32'd1, 32'd1, 0, 4'd1, 1, 0, 0), 0);
    clr();
    repeat (40) begin @(posedge clk); #1; end

    // jumps then SRA
    clr();
    jump = 1; jr = 1; dato1 = 32'h400; inm_ext = 8;
    issue(mk(32'h400, 32'h400, 32'h408, 1, 0, 0, 0, 0), 0);
    jr = 0; dato1 = 0; pc_in = 32'h40; inm_ext = 32'h30;
    issue(mk(32'd0, 32'd0, 32'h30, 1, 0, 0, 0, 0), 0);
    clr();
    op = 8; dato1 = 32'h8000_0000; alu_src = 1; inm_ext = 4; reg_write_in = 1; dest_in = 4;
    issue(mk(32'hF800_0000, 32'h8000_0000, 32'd4, 0, 4'd4, 1, 0, 0), 0);

    // reset mid-MUL
    clr();
    op = 9; dato1 = 9; dato2 = 9; dest_in = 2; reg_write_in = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rstmul_out_valid", out_valid, 0);
    chk("rstmul_alu_out", alu_out, 0);
    chk("rstmul_pc_target", pc_target, 0);
    chk("rstmul_dest", dest_out, 0);
    chk("rstmul_ctrl", {take_branch, reg_write_out, mem_to_reg_out, mem_write_out}, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rstmul_busy", busy, 0);
    clr();
    repeat (40) begin @(posedge clk); #1; end

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
